// File: rtl/note_matcher_pkg.sv
// Shared encodings for the note matcher: grade codes, channel FSM states,
// default timing windows and a saturating-add helper for the streak counter.
package note_matcher_pkg;

  localparam logic [1:0] GRADE_MISS    = 2'b00;
  localparam logic [1:0] GRADE_STRAY   = 2'b01;
  localparam logic [1:0] GRADE_GOOD    = 2'b10;
  localparam logic [1:0] GRADE_PERFECT = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  localparam int DEF_WIN_PERFECT = 2;
  localparam int DEF_WIN_GOOD    = 6;

  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max_val);
    int unsigned sum;
    sum = a + b;
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/note_matcher_ch.sv
// Single-channel note matcher: fetches the next note time, then grades
// press edges against it and reports notes that slipped past unplayed.
module note_matcher_ch
  import note_matcher_pkg::*;
#(
  parameter int TIME_W      = 16,
  parameter int WIN_PERFECT = DEF_WIN_PERFECT,
  parameter int WIN_GOOD    = DEF_WIN_GOOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pause,
  input  logic [TIME_W-1:0] song_time,
  input  logic              press_edge,
  input  logic [TIME_W-1:0] note_time,
  input  logic              note_available,
  output logic              note_request,
  output logic              match_valid,
  output logic [1:0]        match_grade,
  output logic [TIME_W-1:0] match_delta,
  output logic              hit_evt,
  output logic              miss_evt
);

  localparam logic signed [TIME_W:0] WP_S = (TIME_W+1)'(WIN_PERFECT);
  localparam logic signed [TIME_W:0] WG_S = (TIME_W+1)'(WIN_GOOD);

  logic [1:0]         state_q, state_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic               valid_q, valid_d;
  logic [1:0]         grade_q, grade_d;
  logic [TIME_W-1:0]  delta_q, delta_d;
  logic signed [TIME_W:0] diff;
  logic               late, in_perfect, in_good;

  // One extra bit keeps early presses (song_time < T) negative.
  assign diff       = $signed({1'b0, song_time}) - $signed({1'b0, time_q});
  assign late       = diff > WG_S;
  assign in_perfect = (diff <= WP_S) && (diff >= -WP_S);
  assign in_good    = (diff <= WG_S) && (diff >= -WG_S);

  assign note_request = (state_q == ST_FETCH) && !pause;

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    valid_d = 1'b0;
    grade_d = grade_q;
    delta_d = delta_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (!pause && press_edge) begin
          valid_d = 1'b1;
          grade_d = GRADE_STRAY;
          delta_d = '0;
        end
      end
      ST_FETCH: begin
        if (!pause) begin
          if (press_edge) begin
            valid_d = 1'b1;
            grade_d = GRADE_STRAY;
            delta_d = '0;
          end
          if (note_available) begin
            time_d  = note_time;
            state_d = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        // A late note wins over a same-cycle press; the press is absorbed.
        if (!pause) begin
          if (late) begin
            valid_d = 1'b1;
            grade_d = GRADE_MISS;
            delta_d = diff[TIME_W-1:0];
            state_d = ST_FETCH;
          end else if (press_edge) begin
            valid_d = 1'b1;
            if (in_perfect) begin
              grade_d = GRADE_PERFECT;
              delta_d = diff[TIME_W-1:0];
              state_d = ST_FETCH;
            end else if (in_good) begin
              grade_d = GRADE_GOOD;
              delta_d = diff[TIME_W-1:0];
              state_d = ST_FETCH;
            end else begin
              grade_d = GRADE_STRAY;
              delta_d = '0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Good and perfect share the upper grade bit.
  assign hit_evt  = valid_d && grade_d[1];
  assign miss_evt = valid_d && (grade_d == GRADE_MISS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      valid_q <= 1'b0;
      grade_q <= GRADE_MISS;
      delta_q <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      valid_q <= valid_d;
      grade_q <= grade_d;
      delta_q <= delta_d;
    end
  end

  assign match_valid = valid_q;
  assign match_grade = grade_q;
  assign match_delta = delta_q;

endmodule

// File: rtl/note_matcher_array.sv
// Multi-channel note matcher: press-edge detection, an array of per-channel
// matchers and a global saturating hit-streak counter.
module note_matcher_array
  import note_matcher_pkg::*;
#(
  parameter int NUM_CH      = 37,
  parameter int TIME_W      = 16,
  parameter int WIN_PERFECT = DEF_WIN_PERFECT,
  parameter int WIN_GOOD    = DEF_WIN_GOOD,
  parameter int STREAK_W    = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pause,
  input  logic [TIME_W-1:0]          song_time,
  input  logic [NUM_CH-1:0]          ndata,
  input  logic [NUM_CH*TIME_W-1:0]   note_time,
  input  logic [NUM_CH-1:0]          note_available,
  output logic [NUM_CH-1:0]          note_request,
  output logic [NUM_CH-1:0]          match_valid,
  output logic [2*NUM_CH-1:0]        match_grade,
  output logic [NUM_CH*TIME_W-1:0]   match_delta,
  output logic [STREAK_W-1:0]        streak
);

  localparam int unsigned STREAK_MAX = (32'd1 << STREAK_W) - 32'd1;

  logic [NUM_CH-1:0]   prev_ndata_q, prev_ndata_d;
  logic [NUM_CH-1:0]   press_edge;
  logic [NUM_CH-1:0]   hit_vec, miss_vec;
  logic [STREAK_W-1:0] streak_q, streak_d;
  int unsigned         hit_cnt;

  // prev_ndata tracks the keys even while paused, so a held key never
  // produces a late edge when the pause lifts.
  assign press_edge = ndata & ~prev_ndata_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      note_matcher_ch #(
        .TIME_W      (TIME_W),
        .WIN_PERFECT (WIN_PERFECT),
        .WIN_GOOD    (WIN_GOOD)
      ) u_ch (
        .clk            (clk),
        .rst_n          (rst_n),
        .pause          (pause),
        .song_time      (song_time),
        .press_edge     (press_edge[gi]),
        .note_time      (note_time[gi*TIME_W +: TIME_W]),
        .note_available (note_available[gi]),
        .note_request   (note_request[gi]),
        .match_valid    (match_valid[gi]),
        .match_grade    (match_grade[2*gi +: 2]),
        .match_delta    (match_delta[gi*TIME_W +: TIME_W]),
        .hit_evt        (hit_vec[gi]),
        .miss_evt       (miss_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    prev_ndata_d = ndata;
    hit_cnt      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit_cnt = hit_cnt + {31'd0, hit_vec[i]};
    end
    if (|miss_vec) begin
      streak_d = '0;
    end else begin
      streak_d = STREAK_W'(sat_add(32'(streak_q), hit_cnt, STREAK_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_ndata_q <= '0;
      streak_q     <= '0;
    end else begin
      prev_ndata_q <= prev_ndata_d;
      streak_q     <= streak_d;
    end
  end

  assign streak = streak_q;

endmodule

// File: tb/tb_note_matcher_array.sv
// Randomized bench for note_matcher_array: a behavioural game model predicts
// each cycle's outcome into a queue that an independent monitor checks.
module tb_note_matcher_array;

  localparam int NUM_CH     = 4;
  localparam int TIME_W     = 16;
  localparam int WP         = 2;
  localparam int WG         = 6;
  localparam int STREAK_W   = 3;
  localparam int STREAK_MAX = (1 << STREAK_W) - 1;
  localparam int N_CYC      = 3000;

  logic                     clk;
  logic                     rst_n;
  logic                     pause;
  logic [TIME_W-1:0]        song_time;
  logic [NUM_CH-1:0]        ndata;
  logic [NUM_CH*TIME_W-1:0] note_time;
  logic [NUM_CH-1:0]        note_available;
  logic [NUM_CH-1:0]        note_request;
  logic [NUM_CH-1:0]        match_valid;
  logic [2*NUM_CH-1:0]      match_grade;
  logic [NUM_CH*TIME_W-1:0] match_delta;
  logic [STREAK_W-1:0]      streak;

  note_matcher_array #(
    .NUM_CH      (NUM_CH),
    .TIME_W      (TIME_W),
    .WIN_PERFECT (WP),
    .WIN_GOOD    (WG),
    .STREAK_W    (STREAK_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pause          (pause),
    .song_time      (song_time),
    .ndata          (ndata),
    .note_time      (note_time),
    .note_available (note_available),
    .note_request   (note_request),
    .match_valid    (match_valid),
    .match_grade    (match_grade),
    .match_delta    (match_delta),
    .streak         (streak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic                     chk_req;
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        valid;
    logic [2*NUM_CH-1:0]      grade;
    logic [NUM_CH*TIME_W-1:0] delta;
    logic [STREAK_W-1:0]      streak;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Game model: 0 = waiting after reset, 1 = wants a note, 2 = note pending.
  int          mode   [NUM_CH];
  int          tgt    [NUM_CH];
  int          fifo   [NUM_CH][$];
  int          last_t [NUM_CH];
  int          m_grade[NUM_CH];
  int          m_delta[NUM_CH];
  int          m_streak;
  bit [NUM_CH-1:0] m_prev;
  bit          known = 0;
  int          n_hits = 0, n_miss = 0, n_stray = 0;

  task automatic check(input string name, input int ch, input logic [63:0] act,
                       input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s ch=%0d at %0t: got %0h expected %0h", name, ch, $time, act, expv);
    end
  endtask

  task automatic model_step(output exp_t e);
    bit [NUM_CH-1:0] edges;
    bit any_miss;
    int hits;
    int d;
    int ad;
    e = '0;
    e.chk_req = known;
    for (int c = 0; c < NUM_CH; c++) e.req[c] = (mode[c] == 1) && !pause;
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mode[c] = 0; tgt[c] = 0; m_grade[c] = 0; m_delta[c] = 0;
      end
      m_streak = 0;
      m_prev   = '0;
      known    = 1;
    end else begin
      edges    = ndata & ~m_prev;
      hits     = 0;
      any_miss = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        d = int'(song_time) - tgt[c];
        ad = (d < 0) ? -d : d;
        if (mode[c] == 0) begin
          if (!pause && edges[c]) begin
            e.valid[c] = 1; m_grade[c] = 1; m_delta[c] = 0; n_stray++;
          end
          mode[c] = 1;
        end else if (mode[c] == 1) begin
          if (!pause) begin
            if (edges[c]) begin
              e.valid[c] = 1; m_grade[c] = 1; m_delta[c] = 0; n_stray++;
            end
            if (note_available[c]) begin
              tgt[c]  = fifo[c].pop_front();
              mode[c] = 2;
            end
          end
        end else if (!pause) begin
          if (d > WG) begin
            e.valid[c] = 1; m_grade[c] = 0; m_delta[c] = d; mode[c] = 1;
            any_miss = 1; n_miss++;
          end else if (edges[c]) begin
            e.valid[c] = 1;
            if (ad <= WP) begin
              m_grade[c] = 3; m_delta[c] = d; mode[c] = 1; hits++; n_hits++;
            end else if (ad <= WG) begin
              m_grade[c] = 2; m_delta[c] = d; mode[c] = 1; hits++; n_hits++;
            end else begin
              m_grade[c] = 1; m_delta[c] = 0; n_stray++;
            end
          end
        end
      end
      if (any_miss) m_streak = 0;
      else m_streak = (m_streak + hits > STREAK_MAX) ? STREAK_MAX : m_streak + hits;
      m_prev = ndata;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      e.grade[2*c +: 2]           = 2'(m_grade[c]);
      e.delta[c*TIME_W +: TIME_W] = TIME_W'(m_delta[c]);
    end
    e.streak = STREAK_W'(m_streak);
  endtask

  // Driver: inputs change on the falling edge; the model predicts the next rising edge.
  initial begin
    exp_t e;
    int pause_left;
    int near;
    rst_n = 1'b0; pause = 1'b0; song_time = 16'd50; ndata = '0;
    note_time = '0; note_available = '0;
    pause_left = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      last_t[c] = 60 + c;
      mode[c] = 0; tgt[c] = 0; m_grade[c] = 0; m_delta[c] = 0;
    end
    m_streak = 0; m_prev = '0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      rst_n = !(cyc < 3 || (cyc >= 1500 && cyc < 1503));
      if (pause_left > 0) begin
        pause = 1'b1; pause_left--;
      end else if ($urandom_range(39) == 0) begin
        pause = 1'b1; pause_left = $urandom_range(15, 3);
      end else begin
        pause = 1'b0;
      end
      if ($urandom_range(3) != 0) song_time = song_time + 16'd1;
      for (int c = 0; c < NUM_CH; c++) begin
        while (fifo[c].size() < 2) begin
          last_t[c] = last_t[c] + $urandom_range(24, 4);
          fifo[c].push_back(last_t[c]);
        end
        note_time[c*TIME_W +: TIME_W] = TIME_W'(fifo[c][0]);
        note_available[c] = ($urandom_range(3) != 0);
        near = int'(song_time) - tgt[c];
        if (ndata[c]) ndata[c] = ($urandom_range(1) == 0);
        else if (mode[c] == 2 && near >= -(WG + 1) && near <= WG + 1)
          ndata[c] = ($urandom_range(2) == 0);
        else
          ndata[c] = ($urandom_range(11) == 0);
      end
      model_step(e);
      exp_q.push_back(e);
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 0, 64'(exp_q.size()), 64'd0);
    $display("stimulus: hits=%0d misses=%0d strays=%0d", n_hits, n_miss, n_stray);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: request is checked once inputs settle, registered outputs after the edge.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) continue;
      m = exp_q.pop_front();
      if (m.chk_req) check("note_request", 0, 64'(note_request), 64'(m.req));
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        check("match_valid", c, 64'(match_valid[c]), 64'(m.valid[c]));
        check("match_grade", c, 64'(match_grade[2*c +: 2]), 64'(m.grade[2*c +: 2]));
        check("match_delta", c, 64'(match_delta[c*TIME_W +: TIME_W]),
              64'(m.delta[c*TIME_W +: TIME_W]));
      end
      check("streak", 0, 64'(streak), 64'(m.streak));
    end
  end

endmodule

// File: doc/note_matcher_array.md
Name: note_matcher_array

Overview:
- Parametrised multi-channel note matcher for the game pipeline. Sits between the note-input sampler (ndata) and the scoring/display logic.
- Per channel, it fetches the next expected note time from the metadata FIFO via a request/available handshake.
- It detects press edges and grades each press against timing windows: perfect, good, stray or miss. It also detects notes that passed unplayed.
- It keeps a global hit-streak counter across all channels.

Parameters:
- NUM_CH, 37, number of note channels.
- TIME_W, 16, width of song_time and note times (unsigned; song_time is monotonic and never wraps within a song).
- WIN_PERFECT, 2, maximum |song_time - note_time| graded perfect.
- WIN_GOOD, 6, maximum |song_time - note_time| graded good; must be >= WIN_PERFECT.
- STREAK_W, 10, width of the streak counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- pause  in  1  freezes matching, miss detection and fetching.
- song_time  in  TIME_W  current song time.
- ndata  in  NUM_CH  raw note-pressed levels, one bit per channel.
- note_time  in  NUM_CH*TIME_W  per-channel next note time; channel i occupies bits [i*TIME_W +: TIME_W].
- note_available  in  NUM_CH  per-channel metadata valid.
- note_request  out  NUM_CH  per-channel metadata request (pop).
- match_valid  out  NUM_CH  one-cycle event pulse per channel.
- match_grade  out  2*NUM_CH  per-channel grade: 11 perfect, 10 good, 01 stray, 00 miss.
- match_delta  out  NUM_CH*TIME_W  signed (song_time - note_time) at the event; 0 for stray.
- streak  out  STREAK_W  consecutive-hit count.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset values: all outputs 0; every channel goes to IDLE; prev_ndata clears to 0; streak clears to 0.
- Edge detect: edge = ndata & ~prev_ndata. prev_ndata <= ndata every cycle, including during pause. A note held across a pause release therefore produces no edge.
- Per-channel FSM, IDLE -> FETCH -> ARMED:
  - IDLE: lasts one cycle after reset, then moves to FETCH.
  - FETCH: note_request = 1 whenever pause = 0 (combinational from state and pause). When request and available are both high in a cycle, latch note_time and move to ARMED next cycle; request drops in that next cycle.
  - ARMED: hold the latched time T. With pause = 1, no transitions and no events occur.
- Event evaluation in ARMED, with pause = 0; d = song_time - T, computed in TIME_W+1 bits, signed:
  - d > WIN_GOOD: miss (grade 00, delta d), go to FETCH. This holds even if an edge arrives in the same cycle; the edge is absorbed and no stray is reported.
  - Otherwise, on an edge with |d| <= WIN_PERFECT: perfect (11), go to FETCH.
  - Otherwise, on an edge with |d| <= WIN_GOOD: good (10), go to FETCH.
  - Otherwise, on an edge with d < -WIN_GOOD: stray (01, delta 0), stay in ARMED.
- An edge in FETCH or IDLE, with pause = 0, reports stray (01).
- Latency: outputs are registered on the same clock edge that first samples ndata = 1 with prev = 0, or that first sees d > WIN_GOOD. match_valid is high for exactly one cycle. match_grade and match_delta hold their last values when match_valid = 0.
- Streak, evaluated each cycle:
  - If any channel reports a miss, streak <= 0.
  - Otherwise streak <= min(streak + popcount(hits), 2^STREAK_W - 1), where hits are perfect or good events.
  - Strays do not affect streak.
- Pause asserted mid-handshake: the request drops and no latch occurs, even if note_available = 1.
- Reset mid-operation discards latched times. Upstream metadata is not rewound.

Decomposition:
- Shared package: grade encodings (GRADE_MISS/STRAY/GOOD/PERFECT), FSM state encoding, and default window constants.
- One sub-module, note_matcher_ch: a single-channel FSM with its latch, comparator and registered outputs, instantiated NUM_CH times as an array.
- The top level holds prev_ndata, the streak popcount/saturation logic, and the bus slicing.

Test Plan:
- Reset: rst_n = 0 for 3 cycles -> all outputs 0 and note_request = 0. In the 2nd cycle after release -> note_request = all ones.
- Perfect hit: ch5 latches T = 100; rising edge at song_time = 101 -> match_valid[5] pulses once, grade 11, delta +1, streak 0 -> 1, note_request[5] reasserts.
- Good hit and stray: T = 100, edge at 94 -> grade 10, delta -6. Separately, with T = 100, edge at 93 -> grade 01, delta 0, channel stays armed; a later edge at 100 -> grade 11.
- Miss: T = 100, no press, song_time steps to 107 -> grade 00, delta +7, streak resets to 0. An edge in that same cycle -> still a single miss.
- Multi-channel streak: streak = 4, three simultaneous perfect hits -> 7. Hits plus one miss in the same cycle -> 0. With STREAK_W = 3 and streak = 6, two hits -> streak saturates at 7.
- Pause:
  - Edge during pause -> no event.
  - song_time passes T + 10 during pause -> no miss. The miss fires on the first unpaused cycle.
  - A key held through the pause release -> no event.
